// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared encodings for the EX forwarding selects and the hazard sequencer.
package forwarding_hazard_unit_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int CNT_W = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;
endpackage

// File: rtl/forwarding_hazard_unit_fwd_compare.sv
// Forward-select decode for one EX operand; EX/MEM producer beats MEM/WB.
module fwd_compare
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] i_src,
  input  logic [REG_BITS-1:0] i_rd_ex,
  input  logic                i_regWrite_ex,
  input  logic                i_memRead_ex,
  input  logic [REG_BITS-1:0] i_rd_mem,
  input  logic                i_regWrite_mem,
  output logic [1:0]          o_sel
);
  logic w_hit_ex, w_hit_mem;

  // A load in EX has no ALU result yet, so it never forwards from EX/MEM.
  assign w_hit_ex  = i_regWrite_ex & ~i_memRead_ex & (i_rd_ex != '0) & (i_rd_ex == i_src);
  assign w_hit_mem = i_regWrite_mem & (i_rd_mem != '0) & (i_rd_mem == i_src);

  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_ex)       o_sel = FWD_MEM;
    else if (w_hit_mem) o_sel = FWD_WB;
  end
endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding selects, load-use stall and branch flush control for the 5-stage pipe.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int REG_BITS   = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [REG_BITS-1:0] rs_id,
  input  logic [REG_BITS-1:0] rt_id,
  input  logic [REG_BITS-1:0] rd_ex,
  input  logic                regWrite_ex,
  input  logic                memRead_ex,
  input  logic                branchTaken_mem,
  output logic [1:0]          forwardA,
  output logic [1:0]          forwardB,
  output logic                pcWrite,
  output logic                ifidWrite,
  output logic                bubble,
  output logic                flushIfId,
  output logic                flushExMem,
  output logic                stalled
);
  localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_STALL - 1);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [REG_BITS-1:0] r_rd_mem;
  logic                r_regWrite_mem;
  logic [1:0]          r_fwdA, r_fwdB;
  logic [1:0]          w_fwdA_nxt, w_fwdB_nxt;
  logic                w_hazard;

  assign w_hazard = memRead_ex & regWrite_ex & (rd_ex != '0) &
                    ((rd_ex == rs_id) | (rd_ex == rt_id));

  fwd_compare #(.REG_BITS(REG_BITS)) u_fwd_a (
    .i_src(rs_id), .i_rd_ex(rd_ex), .i_regWrite_ex(regWrite_ex),
    .i_memRead_ex(memRead_ex), .i_rd_mem(r_rd_mem),
    .i_regWrite_mem(r_regWrite_mem), .o_sel(w_fwdA_nxt)
  );

  fwd_compare #(.REG_BITS(REG_BITS)) u_fwd_b (
    .i_src(rt_id), .i_rd_ex(rd_ex), .i_regWrite_ex(regWrite_ex),
    .i_memRead_ex(memRead_ex), .i_rd_mem(r_rd_mem),
    .i_regWrite_mem(r_regWrite_mem), .o_sel(w_fwdB_nxt)
  );

  always_comb begin
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    bubble      = 1'b0;
    flushIfId   = 1'b0;
    flushExMem  = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (branchTaken_mem) begin
      // The taken branch squashes everything younger, including a pending stall.
      bubble      = 1'b1;
      flushIfId   = 1'b1;
      flushExMem  = 1'b1;
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
    end else if (r_state == ST_STALL) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      bubble    = 1'b1;
      if (r_cnt <= CNT_W'(1)) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end else if (w_hazard) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      bubble      = 1'b1;
      w_cnt_nxt   = STALL_INIT;
      w_state_nxt = (LOAD_STALL > 1) ? ST_STALL : ST_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= ST_RUN;
      r_cnt          <= '0;
      r_rd_mem       <= '0;
      r_regWrite_mem <= 1'b0;
      r_fwdA         <= FWD_REG;
      r_fwdB         <= FWD_REG;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_rd_mem       <= rd_ex;
      r_regWrite_mem <= regWrite_ex & ~branchTaken_mem;
      // Selects follow the instruction into EX; a bubble carries no operands.
      if (bubble) begin
        r_fwdA <= FWD_REG;
        r_fwdB <= FWD_REG;
      end else begin
        r_fwdA <= w_fwdA_nxt;
        r_fwdB <= w_fwdB_nxt;
      end
    end
  end

  assign forwardA = r_fwdA;
  assign forwardB = r_fwdB;
  assign stalled  = (r_state == ST_STALL);
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Checks two instances (LOAD_STALL 1 and 3) with vectors, directed sequences and a random model run.
module tb_forwarding_hazard_unit;
  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] rs_id, rt_id, rd_ex;
  logic       regWrite_ex, memRead_ex, branchTaken_mem;

  logic [1:0] fa [2];
  logic [1:0] fb [2];
  logic       pcw [2];
  logic       ifw [2];
  logic       bub [2];
  logic       fli [2];
  logic       fle [2];
  logic       st  [2];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  forwarding_hazard_unit #(.LOAD_STALL(1), .REG_BITS(5)) dut1 (
    .clock(clock), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .rd_ex(rd_ex),
    .regWrite_ex(regWrite_ex), .memRead_ex(memRead_ex), .branchTaken_mem(branchTaken_mem),
    .forwardA(fa[0]), .forwardB(fb[0]), .pcWrite(pcw[0]), .ifidWrite(ifw[0]),
    .bubble(bub[0]), .flushIfId(fli[0]), .flushExMem(fle[0]), .stalled(st[0])
  );

  forwarding_hazard_unit #(.LOAD_STALL(3), .REG_BITS(5)) dut3 (
    .clock(clock), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .rd_ex(rd_ex),
    .regWrite_ex(regWrite_ex), .memRead_ex(memRead_ex), .branchTaken_mem(branchTaken_mem),
    .forwardA(fa[1]), .forwardB(fb[1]), .pcWrite(pcw[1]), .ifidWrite(ifw[1]),
    .bubble(bub[1]), .flushIfId(fli[1]), .flushExMem(fle[1]), .stalled(st[1])
  );

  // Reference model: remaining stall cycles as a plain count, plus the EX/MEM shadow.
  int         m_left   [2];
  logic [4:0] m_rd_mem [2];
  logic       m_rw_mem [2];
  logic [1:0] m_fa     [2];
  logic [1:0] m_fb     [2];
  int         m_ls     [2] = '{1, 3};

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input int k);
    if (regWrite_ex && !memRead_ex && rd_ex != 0 && rd_ex == src) return 2'b10;
    if (m_rw_mem[k] && m_rd_mem[k] != 0 && m_rd_mem[k] == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_hazard();
    return memRead_ex && regWrite_ex && rd_ex != 0 && (rd_ex == rs_id || rd_ex == rt_id);
  endfunction

  function automatic logic [9:0] ref_out(input int k);
    logic stl, p, i, b, f;
    stl = (m_left[k] > 0);
    p = 1; i = 1; b = 0; f = 0;
    if (branchTaken_mem) begin b = 1; f = 1; end
    else if (stl || ref_hazard()) begin p = 0; i = 0; b = 1; end
    return {m_fa[k], m_fb[k], p, i, b, f, f, stl};
  endfunction

  task automatic model_edge(input int k);
    logic stl, haz;
    stl = (m_left[k] > 0);
    haz = ref_hazard();
    if (!reset) begin
      m_left[k] = 0; m_rd_mem[k] = 0; m_rw_mem[k] = 0; m_fa[k] = 0; m_fb[k] = 0;
    end else begin
      if (branchTaken_mem || stl || haz) begin
        m_fa[k] = 0; m_fb[k] = 0;
      end else begin
        m_fa[k] = ref_fwd(rs_id, k); m_fb[k] = ref_fwd(rt_id, k);
      end
      if (branchTaken_mem) m_left[k] = 0;
      else if (stl)        m_left[k] = m_left[k] - 1;
      else if (haz)        m_left[k] = m_ls[k] - 1;
      m_rd_mem[k] = rd_ex;
      m_rw_mem[k] = regWrite_ex && !branchTaken_mem;
    end
  endtask

  task automatic tick();
    model_edge(0);
    model_edge(1);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic [4:0] rs, rt, rd, input logic rw, mr, br);
    rs_id = rs; rt_id = rt; rd_ex = rd; regWrite_ex = rw; memRead_ex = mr; branchTaken_mem = br;
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_dut(input int k, input string tag, input logic [1:0] efa, efb,
                         input logic ep, ei, eb, efi, efe, est);
    chk({tag, ".forwardA"},   fa[k],  efa);
    chk({tag, ".forwardB"},   fb[k],  efb);
    chk({tag, ".pcWrite"},    pcw[k], ep);
    chk({tag, ".ifidWrite"},  ifw[k], ei);
    chk({tag, ".bubble"},     bub[k], eb);
    chk({tag, ".flushIfId"},  fli[k], efi);
    chk({tag, ".flushExMem"}, fle[k], efe);
    chk({tag, ".stalled"},    st[k],  est);
  endtask

  task automatic do_reset();
    reset = 0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1;
    #1;
  endtask

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       rw, mr, br;
    logic [1:0] fa, fb;
    logic       pcw, ifw, bub, fl;
  } vec_t;

  vec_t tv [11];

  initial begin
    // Vector i's expected forwards reflect the edge after vector i-1.
    tv[0]  = '{5'd3, 5'd7, 5'd3, 1, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0};
    tv[1]  = '{5'd1, 5'd5, 5'd5, 1, 0, 0, 2'b10, 2'b00, 1, 1, 0, 0};
    tv[2]  = '{5'd0, 5'd5, 5'd5, 1, 0, 0, 2'b00, 2'b10, 1, 1, 0, 0};
    tv[3]  = '{5'd2, 5'd5, 5'd6, 1, 0, 0, 2'b00, 2'b10, 1, 1, 0, 0};
    tv[4]  = '{5'd0, 5'd0, 5'd0, 1, 0, 0, 2'b00, 2'b01, 1, 1, 0, 0};
    tv[5]  = '{5'd9, 5'd4, 5'd4, 1, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0};
    tv[6]  = '{5'd9, 5'd4, 5'd0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0};
    tv[7]  = '{5'd4, 5'd8, 5'd8, 0, 0, 0, 2'b00, 2'b01, 1, 1, 0, 0};
    tv[8]  = '{5'd8, 5'd0, 5'd8, 1, 0, 1, 2'b00, 2'b00, 1, 1, 1, 1};
    tv[9]  = '{5'd8, 5'd0, 5'd0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0};
    tv[10] = '{5'd0, 5'd0, 5'd0, 1, 1, 0, 2'b00, 2'b00, 1, 1, 0, 0};

    @(negedge clock);
    do_reset();
    chk_dut(0, "reset1", 2'b00, 2'b00, 1, 1, 0, 0, 0, 0);
    chk_dut(1, "reset3", 2'b00, 2'b00, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].rs, tv[i].rt, tv[i].rd, tv[i].rw, tv[i].mr, tv[i].br);
      chk_dut(0, $sformatf("vec%0d", i), tv[i].fa, tv[i].fb, tv[i].pcw, tv[i].ifw,
              tv[i].bub, tv[i].fl, tv[i].fl, 0);
      tick();
    end

    // LOAD_STALL=3: hazard cycle plus two STALL cycles, then RUN with 00 selects.
    do_reset();
    drive(0, 4, 4, 1, 1, 0);
    chk_dut(1, "ls3_haz", 2'b00, 2'b00, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 4, 0, 0, 0, 0);
    chk_dut(1, "ls3_s1", 2'b00, 2'b00, 0, 0, 1, 0, 0, 1);
    tick();
    chk_dut(1, "ls3_s2", 2'b00, 2'b00, 0, 0, 1, 0, 0, 1);
    tick();
    chk_dut(1, "ls3_run", 2'b00, 2'b00, 1, 1, 0, 0, 0, 0);
    tick();
    chk_dut(1, "ls3_adv", 2'b00, 2'b00, 1, 1, 0, 0, 0, 0);

    // Taken branch during STALL cancels it and kills the EX/MEM write.
    do_reset();
    drive(0, 4, 4, 1, 1, 0);
    tick();
    drive(0, 4, 4, 1, 0, 1);
    chk_dut(1, "flush_stall", 2'b00, 2'b00, 1, 1, 1, 1, 1, 1);
    tick();
    drive(4, 4, 0, 0, 0, 0);
    chk_dut(1, "flush_after", 2'b00, 2'b00, 1, 1, 0, 0, 0, 0);
    tick();
    chk_dut(1, "flush_nofwd", 2'b00, 2'b00, 1, 1, 0, 0, 0, 0);

    // Reset asserted mid-stall.
    do_reset();
    drive(4, 0, 4, 1, 1, 0);
    tick();
    chk("rst_mid_pre.stalled", st[1], 1);
    reset = 0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1;
    #1;
    chk_dut(1, "rst_mid", 2'b00, 2'b00, 1, 1, 0, 0, 0, 0);

    // Random run against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) != 0);
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0));
      for (int k = 0; k < 2; k++) begin
        logic [9:0] act, exp;
        act = {fa[k], fb[k], pcw[k], ifw[k], bub[k], fli[k], fle[k], st[k]};
        exp = ref_out(k);
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL rand[%0d] dut%0d: got %h expected %h", c, k, act, exp);
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
